snail_serializer: RTL and testbench
===================================

Name: snail_serializer

Overview:
- Upstream feeder for the serial "snail" pattern detector.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a single serial line `d_out`. That line drives the detector's D input directly.
- Drives `d_out` low whenever no data bit is on the line, so idle time never forms spurious patterns.
- An optional programmable gap of zero-cycles separates consecutive words.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- GAP, 0, number of forced-zero cycles inserted after each word; legal range 0..255.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- res  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  parallel word; sampled only on handshake.
- in_ready  output  1  block can accept a word this cycle.
- d_out  output  1  serial bit to detector D.
- bit_valid  output  1  high while d_out carries a data bit.
- word_done  output  1  high during the cycle d_out carries a word's LSB.
- busy  output  1  high in S_SHIFT or S_GAP.

Behaviour:
- Reset: on a clock edge with res=1:
  - state=S_IDLE, shift register=0, bit and gap counters=0.
  - Registered outputs take these values after the edge: d_out=0, bit_valid=0, word_done=0, busy=0.
  - in_ready=1 after the edge, because it decodes S_IDLE.
  - res has priority over a simultaneous handshake; that word is dropped.
- Handshake:
  - A transfer occurs at a rising edge with in_valid=1 and in_ready=1.
  - in_valid while in_ready=0 is ignored; the block never latches in_data outside a transfer.
- Latency: a word accepted at edge k puts in_data[WIDTH-1] on d_out after edge k, i.e. during cycle k+1. Bit i (MSB=WIDTH-1) appears in cycle k+WIDTH-i.
- States (enum S_IDLE, S_SHIFT, S_GAP):
  - S_IDLE: d_out=0, bit_valid=0, in_ready=1. On transfer go to S_SHIFT, load shifter, bit_cnt=WIDTH-1.
  - S_SHIFT: d_out=shifter MSB, bit_valid=1. Each cycle shift left with zero fill and decrement bit_cnt.
    - When bit_cnt=0 this is the last bit: word_done=1.
    - Next state: if GAP=0 and a transfer occurs, reload and stay in S_SHIFT (no bubble).
    - Otherwise go to S_GAP when GAP>0, or S_IDLE when GAP=0.
  - S_GAP: d_out=0, bit_valid=0. gap_cnt counts 0..GAP-1.
    - On the last gap cycle: a transfer goes to S_SHIFT, otherwise go to S_IDLE.
- in_ready = (state==S_IDLE) OR (S_SHIFT and bit_cnt==0 and GAP==0) OR (S_GAP and gap_cnt==GAP-1).
  - Combinational from state and counters only; never depends on in_valid.
- d_out, bit_valid, word_done and busy are registered. The state register directly implies all four; no combinational path exists from in_valid or in_data.
- Counter widths:
  - bit_cnt is $clog2(WIDTH) bits.
  - gap_cnt is 8 bits; GAP=0 makes it unused.
  - No wrap beyond the defined ranges.
- Reset mid-word: word aborted; d_out=0 and bit_valid=0 from the next cycle; no partial word_done.
- Throughput: WIDTH+GAP cycles per word when in_valid is held continuously.

Decomposition:
- Package snail_pkg:
  - typedef enum logic [1:0] ser_state_t {S_IDLE, S_SHIFT, S_GAP}.
  - localparam defaults SER_WIDTH=8, SER_GAP=0.
- No sub-module: shifter and both counters live inline; each is under ~20 lines.
- Parameter range checks go in an initial-block assertion.

Test Plan:
- Reset, then GAP=0, accept 8'b1100_0000 at edge k:
  - d_out = 1,1,0,0,0,0,0,0 in cycles k+1..k+8.
  - bit_valid=1 for those 8 cycles.
  - word_done=1 only in cycle k+8.
  - Chained detector F=1 exactly once.
- GAP=0, in_valid held with 8'hA5 then 8'hFF:
  - 16 contiguous bits 1010_0101_1111_1111 with bit_valid never dropping.
  - in_ready high in cycles k, k+8 and k+16 only.
- GAP=3, two words 8'h81:
  - Stream is 1000_0001, then 000, then 1000_0001.
  - in_ready=1 in the third gap cycle.
  - The detector never sees two adjacent 1s.
- Assert res=1 after 3 bits of 8'hF0:
  - Next cycle d_out=0, bit_valid=0, busy=0, in_ready=1, no word_done.
  - A following word 8'h80 serializes cleanly from its MSB.
- in_valid=1 with 8'h55 while mid-word (in_ready=0):
  - Word is ignored; only the in-flight word appears on d_out.
  - 8'h55 is transferred only when in_ready next rises.
- res=1 and in_valid=1 on the same edge: word dropped; state S_IDLE; d_out stays 0.

Source files
------------

// File: rtl/snail_pkg.sv
// Shared types and defaults for the snail serializer.
package snail_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH = 8;
  localparam int SER_GAP   = 0;

endpackage

// File: rtl/snail_serializer.sv
// Parallel-to-serial feeder for the snail pattern detector. Words arrive on a
// valid/ready handshake and leave MSB-first on d_out, one bit per clock, with
// an optional run of forced-zero gap cycles after each word.
module snail_serializer
  import snail_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int GAP   = SER_GAP
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             d_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic             NO_GAP   = (GAP == 0);

  // Out-of-range parameters stop elaboration.
  if (WIDTH < 2 || WIDTH > 32 || GAP < 0 || GAP > 255) begin : g_param_check
    $error("snail_serializer: WIDTH must be 2..32 and GAP 0..255");
  end

  ser_state_t       state, state_n;
  logic [WIDTH-1:0] shifter, shifter_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [7:0]       gap_cnt, gap_cnt_n;
  logic             xfer;

  // Ready decodes state and counters only, so it never waits on in_valid.
  assign in_ready = (state == S_IDLE)
                 || (state == S_SHIFT && bit_cnt == '0 && NO_GAP)
                 || (state == S_GAP && gap_cnt == GAP_LAST);
  assign xfer = in_valid && in_ready;

  // Next-state, shifter and counter updates.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n   = state;
    shifter_n = shifter;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    unique case (state)
      S_IDLE: begin
        if (xfer) begin
          state_n   = S_SHIFT;
          shifter_n = in_data;
          bit_cnt_n = BIT_LAST;
        end
      end
      S_SHIFT: begin
        shifter_n = {shifter[WIDTH-2:0], 1'b0};
        if (bit_cnt != '0) begin
          bit_cnt_n = bit_cnt - 1'b1;
        end else if (xfer) begin
          // Back-to-back word with no gap: reload without a bubble.
          shifter_n = in_data;
          bit_cnt_n = BIT_LAST;
        end else if (!NO_GAP) begin
          state_n   = S_GAP;
          gap_cnt_n = 8'd0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt != GAP_LAST) begin
          gap_cnt_n = gap_cnt + 8'd1;
        end else begin
          gap_cnt_n = 8'd0;
          if (xfer) begin
            state_n   = S_SHIFT;
            shifter_n = in_data;
            bit_cnt_n = BIT_LAST;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (res) begin
      state     <= S_IDLE;
      shifter   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= 8'd0;
      d_out     <= 1'b0;
      bit_valid <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      shifter   <= shifter_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      d_out     <= (state_n == S_SHIFT) && shifter_n[WIDTH-1];
      bit_valid <= (state_n == S_SHIFT);
      word_done <= (state_n == S_SHIFT) && (bit_cnt_n == '0);
      busy      <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_snail_serializer.sv
// Bench for snail_serializer: one instance without gap, one with a 3-cycle
// gap, both compared every cycle against a queue of expected line cycles.
module tb_snail_serializer;

  typedef struct packed {
    logic d;
    logic bv;
    logic wd;
  } line_t;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         res;
  logic         v0, v3;
  logic [W-1:0] d0, d3;
  logic         rdy0, dout0, bv0, wd0, busy0;
  logic         rdy3, dout3, bv3, wd3, busy3;

  int checks   = 0;
  int failures = 0;

  line_t q0[$];
  line_t q3[$];

  logic [31:0] hist0, raw3;
  int          wd_cnt0, adj3;
  logic        prev3;

  always #5 clk = ~clk;

  snail_serializer #(.WIDTH(W), .GAP(0)) dut0 (
    .clk(clk), .res(res), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
    .d_out(dout0), .bit_valid(bv0), .word_done(wd0), .busy(busy0)
  );

  snail_serializer #(.WIDTH(W), .GAP(3)) dut3 (
    .clk(clk), .res(res), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .d_out(dout3), .bit_valid(bv3), .word_done(wd3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A word occupies WIDTH data cycles (MSB first) followed by gap zero cycles.
  function automatic void push_word(inout line_t q[$], input logic [W-1:0] w, input int gap);
    for (int i = W - 1; i >= 0; i--) q.push_back('{d: w[i], bv: 1'b1, wd: (i == 0)});
    for (int i = 0; i < gap; i++) q.push_back('{d: 1'b0, bv: 1'b0, wd: 1'b0});
  endfunction

  // One clock cycle: check outputs at negedge, drive inputs, advance the model.
  task automatic step(input logic r, input logic iv0, input logic [W-1:0] id0,
                      input logic iv3, input logic [W-1:0] id3);
    line_t e0, e3;
    logic  x0, x3;
    e0 = (q0.size() > 0) ? q0[0] : '0;
    e3 = (q3.size() > 0) ? q3[0] : '0;
    check("d_out0",     32'(dout0), 32'(e0.d));
    check("bit_valid0", 32'(bv0),   32'(e0.bv));
    check("word_done0", 32'(wd0),   32'(e0.wd));
    check("busy0",      32'(busy0), 32'(q0.size() > 0));
    check("in_ready0",  32'(rdy0),  32'(q0.size() <= 1));
    check("d_out3",     32'(dout3), 32'(e3.d));
    check("bit_valid3", 32'(bv3),   32'(e3.bv));
    check("word_done3", 32'(wd3),   32'(e3.wd));
    check("busy3",      32'(busy3), 32'(q3.size() > 0));
    check("in_ready3",  32'(rdy3),  32'(q3.size() <= 1));
    if (bv0) hist0 = {hist0[30:0], dout0};
    if (wd0) wd_cnt0++;
    if (busy3) raw3 = {raw3[30:0], dout3};
    if (dout3 && prev3) adj3++;
    prev3 = dout3;
    res = r; v0 = iv0; d0 = id0; v3 = iv3; d3 = id3;
    x0 = !r && iv0 && (q0.size() <= 1);
    x3 = !r && iv3 && (q3.size() <= 1);
    @(posedge clk);
    if (r) begin
      q0.delete();
      q3.delete();
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      if (q3.size() > 0) void'(q3.pop_front());
      if (x0) push_word(q0, id0, 0);
      if (x3) push_word(q3, id3, 3);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    hist0 = '0; raw3 = '0; wd_cnt0 = 0; adj3 = 0; prev3 = 1'b0;
    res = 1'b1; v0 = 1'b0; v3 = 1'b0; d0 = '0; d3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then a single 8'hC0 word on the no-gap instance.
    step(1'b0, 1'b1, 8'hC0, 1'b0, '0);
    idle(9);
    check("c0_stream", hist0, 32'h0000_00C0);
    check("c0_word_done_count", 32'(wd_cnt0), 32'd1);

    // A5 then FF with valid held: 16 contiguous bits, no bubble.
    hist0 = '0;
    step(1'b0, 1'b1, 8'hA5, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'hFF, 1'b0, '0);
    idle(10);
    check("a5ff_stream", hist0, 32'h0000_A5FF);

    // Two 8'h81 words through the 3-cycle-gap instance.
    raw3 = '0; adj3 = 0; prev3 = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b1, 8'h81);
    idle(14);
    check("gap3_raw_stream", raw3, 32'h0020_4408);
    check("gap3_no_adjacent_ones", 32'(adj3), 32'd0);

    // Reset after three bits of 8'hF0, then a clean 8'h80.
    step(1'b0, 1'b1, 8'hF0, 1'b0, '0);
    idle(2);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    hist0 = '0; wd_cnt0 = 0;
    step(1'b0, 1'b1, 8'h80, 1'b0, '0);
    idle(9);
    check("after_reset_stream", hist0, 32'h0000_0080);
    check("after_reset_word_done_count", 32'(wd_cnt0), 32'd1);

    // 8'h55 offered mid-word must wait for the next ready.
    hist0 = '0;
    step(1'b0, 1'b1, 8'h3C, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h55, 1'b0, '0);
    idle(10);
    check("held_word_stream", hist0, 32'h0000_3C55);

    // Reset coinciding with a handshake drops the word.
    hist0 = '0;
    step(1'b1, 1'b1, 8'hAA, 1'b1, 8'hAA);
    idle(4);
    check("dropped_word_stream", hist0, 32'h0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0, W'($urandom),
           $urandom_range(0, 3) != 0, W'($urandom));
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
